spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_pkg.sv | 12 +
 rtl/spi_master.sv | 97 +++++++++
 2 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and the idle byte
// reported on q after reset.
package spi_master_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master paced by external pe/ne edge-slot enables.
// A rising edge on io starts one 8-bit transfer; q holds the last received byte.
module spi_master
  import spi_master_pkg::*;
#(
  parameter logic IDLE_MOSI = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ne,
  input  logic       pe,
  input  logic       io,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       busy,
  output logic       ck,
  output logic       mosi,
  input  logic       miso
);

  spi_state_t state, state_n;
  logic       io_d;
  logic       trig;
  logic       ck_n;
  logic       mosi_n;
  logic [7:0] tx, tx_n;
  logic [7:0] rx, rx_n;
  logic [7:0] q_n;
  logic [2:0] cnt, cnt_n;

  assign trig = io && !io_d;
  assign busy = (state == SHIFT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      io_d  <= 1'b0;
      ck    <= 1'b0;
      mosi  <= IDLE_MOSI;
      tx    <= IDLE_BYTE;
      rx    <= '0;
      q     <= IDLE_BYTE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      io_d  <= io;
      ck    <= ck_n;
      mosi  <= mosi_n;
      tx    <= tx_n;
      rx    <= rx_n;
      q     <= q_n;
      cnt   <= cnt_n;
    end
  end

  // The current ck level selects which enable is honoured, so pe and ne
  // arriving together advance exactly one half-period.
  always_comb begin
    state_n = state;
    ck_n    = ck;
    mosi_n  = mosi;
    tx_n    = tx;
    rx_n    = rx;
    q_n     = q;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (trig) begin
          state_n = SHIFT;
          tx_n    = d;
          mosi_n  = d[7];
          cnt_n   = '0;
          ck_n    = 1'b0;
        end
      end
      SHIFT: begin
        if (!ck) begin
          if (pe) begin
            ck_n = 1'b1;
            rx_n = {rx[6:0], miso};
          end
        end else if (ne) begin
          ck_n   = 1'b0;
          tx_n   = {tx[6:0], 1'b0};
          mosi_n = tx[6];
          cnt_n  = cnt + 3'd1;
          if (cnt == 3'd7) begin
            q_n     = rx;
            mosi_n  = IDLE_MOSI;
            state_n = IDLE;
          end
        end
      end
    endcase
  end

endmodule
